mem_load_controller: RTL
========================

Name: mem_load_controller

Overview:
- Host-side sequencer for the cpu block.
- Receives a byte stream and loads instruction memory, then data memory.
- Drives the cpu `status` code to start execution and waits for `end_process`.
- Streams a fixed window of data memory back out over a valid/ready byte interface.
- Sits between the host byte link (UART or testbench) and the cpu top level.

Parameters:
- IM_DEPTH, 256: instruction words available. A header count above this value is an error.
- DM_DEPTH, 256: data bytes available. A header count above this value is an error.
- DUMP_LEN, 16: number of data-memory bytes returned after the run, starting at address 0. Range 1..DM_DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a session. Honoured only in IDLE, DONE or ERR.
- rx_valid  in  1  rx_data holds a byte. Consumed on every cycle where it is high in a load state; there is no backpressure.
- rx_data  in  8  incoming byte.
- end_process  in  1  from cpu; high means the program has finished.
- dm_rdata  in  8  data memory read data, valid one cycle after dm_addr is presented.
- status  out  2  to cpu: 00 hold, 01 load instr, 10 load data, 11 run.
- im_we  out  1  instruction memory write strobe.
- im_addr  out  16  instruction memory address.
- im_wdata  out  16  instruction word.
- dm_we  out  1  data memory write strobe.
- dm_addr  out  16  data memory address.
- dm_wdata  out  8  data byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts the byte.
- tx_data  out  8  readback byte.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- err  out  1  header count exceeded its depth.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; all outputs 0; counters 0.
  - Reset mid-session aborts immediately with no further writes.
- States: IDLE, IC_HI, IC_LO, I_HI, I_LO, DC_HI, DC_LO, D_BYTE, RUN, RD_REQ, RD_WAIT, TX, DONE, ERR.
- IDLE/DONE/ERR + start -> IC_HI; clears err and all counters.
- Byte-consuming states advance only on a cycle with rx_valid=1.
- IC_HI, IC_LO: assemble the 16-bit instruction count N, high byte first.
  - N > IM_DEPTH -> ERR.
  - N = 0 -> DC_HI.
  - Otherwise -> I_HI.
- I_HI: latch the high byte.
- I_LO: in the same cycle, assert im_we=1 for exactly one cycle with im_addr = word index and im_wdata = {hi, lo}.
  - Increment the index.
  - After word N-1 -> DC_HI; otherwise -> I_HI.
- status = 01 from IC_HI through I_LO.
- DC_HI, DC_LO: assemble data count M, high byte first.
  - M > DM_DEPTH -> ERR.
  - M = 0 -> RUN.
  - Otherwise -> D_BYTE.
- D_BYTE: dm_we=1 for one cycle with dm_addr = byte index and dm_wdata = rx_data.
  - After byte M-1 -> RUN.
- status = 10 from DC_HI through D_BYTE.
- RUN: status = 11. Wait for end_process=1, then -> RD_REQ.
  - rx bytes received in RUN are ignored.
  - If end_process is already high on entry, leave RUN on the next cycle.
- RD_REQ: status = 00; drive dm_addr = read index; -> RD_WAIT.
- RD_WAIT: capture dm_rdata into tx_data; assert tx_valid; -> TX.
- TX: hold tx_valid and tx_data stable until tx_ready=1.
  - On acceptance: deassert tx_valid in the next cycle and increment the read index.
  - After DUMP_LEN bytes -> DONE; otherwise -> RD_REQ.
- Write strobes are never asserted outside I_LO and D_BYTE.
- Write strobes and tx_valid are never high in the same cycle.
- DONE: all strobes 0, status 00.
- ERR: err=1, status 00, all strobes 0. Stays in ERR until start or reset.
- Counts and indices are 16 bits. Addresses are zero-extended indices and never wrap, because the depth checks bound them.
- start outside IDLE/DONE/ERR is ignored.

Test Plan:
- Load N=2 words (0x12 0x34 0xAB 0xCD), M=1 byte (0x5A). Expected:
  - im writes 0x1234@0 and 0xABCD@1.
  - dm write 0x5A@0.
  - status sequence 01 -> 10 -> 11.
- With end_process held low for 50 cycles, then pulsed:
  - status stays 11 until the pulse.
  - DUMP_LEN=16 bytes from addresses 0..15 appear on tx, byte 0 = 0x5A.
- tx_ready low for 5 cycles during byte 3: tx_valid and tx_data stay stable, no byte is skipped or duplicated, total accepted = 16.
- Header N=IM_DEPTH+1 (0x01 0x01): err=1, state ERR, no im_we pulses. A following start clears err.
- N=0, M=0: goes straight to status 11 with no write strobes.
- Sparse rx_valid (1 in 4 cycles): same memory image as the dense case.
- rst_n low during I_HI after 1 word: all outputs 0 the next cycle, and no further im_we pulses.

Source files
------------

// File: rtl/mem_load_controller.sv
// Host-side loader for the cpu: streams instruction and data images into memory from a byte link,
// starts the program, then returns a fixed window of data memory over a valid/ready byte port.
module mem_load_controller #(
    parameter int IM_DEPTH = 256,
    parameter int DM_DEPTH = 256,
    parameter int DUMP_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        end_process,
    input  logic [7:0]  dm_rdata,
    output logic [1:0]  status,
    output logic        im_we,
    output logic [15:0] im_addr,
    output logic [15:0] im_wdata,
    output logic        dm_we,
    output logic [15:0] dm_addr,
    output logic [7:0]  dm_wdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, IC_HI, IC_LO, I_HI, I_LO, DC_HI, DC_LO, D_BYTE,
        RUN, RD_REQ, RD_WAIT, TX, DONE, ERR
    } state_t;

    localparam logic [15:0] IM_MAX  = 16'(IM_DEPTH);
    localparam logic [15:0] DM_MAX  = 16'(DM_DEPTH);
    localparam logic [15:0] RD_LAST = 16'(DUMP_LEN - 1);

    state_t      state;
    logic [7:0]  hi_byte;
    logic [15:0] cnt;
    logic [15:0] idx;
    logic [15:0] rd_idx;
    logic [15:0] rx_word;
    logic [15:0] idx_next;

    assign rx_word  = {hi_byte, rx_data};
    assign idx_next = idx + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hi_byte  <= '0;
            cnt      <= '0;
            idx      <= '0;
            rd_idx   <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state   <= IC_HI;
                        hi_byte <= '0;
                        cnt     <= '0;
                        idx     <= '0;
                        rd_idx  <= '0;
                    end
                end
                IC_HI, I_HI, DC_HI: begin
                    if (rx_valid) begin
                        hi_byte <= rx_data;
                        state   <= (state == IC_HI) ? IC_LO :
                                   (state == I_HI)  ? I_LO  : DC_LO;
                    end
                end
                IC_LO: begin
                    if (rx_valid) begin
                        cnt <= rx_word;
                        idx <= '0;
                        if (rx_word > IM_MAX)     state <= ERR;
                        else if (rx_word == '0)   state <= DC_HI;
                        else                      state <= I_HI;
                    end
                end
                I_LO: begin
                    if (rx_valid) begin
                        idx   <= idx_next;
                        state <= (idx_next == cnt) ? DC_HI : I_HI;
                    end
                end
                DC_LO: begin
                    if (rx_valid) begin
                        cnt <= rx_word;
                        idx <= '0;
                        if (rx_word > DM_MAX)     state <= ERR;
                        else if (rx_word == '0)   state <= RUN;
                        else                      state <= D_BYTE;
                    end
                end
                D_BYTE: begin
                    if (rx_valid) begin
                        idx   <= idx_next;
                        state <= (idx_next == cnt) ? RUN : D_BYTE;
                    end
                end
                RUN: begin
                    if (end_process) begin
                        rd_idx <= '0;
                        state  <= RD_REQ;
                    end
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: begin
                    // memory answers one cycle after the address, so the byte is valid now
                    tx_data  <= dm_rdata;
                    tx_valid <= 1'b1;
                    state    <= TX;
                end
                TX: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        rd_idx   <= rd_idx + 16'd1;
                        state    <= (rd_idx == RD_LAST) ? DONE : RD_REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write strobes fire in the same cycle the completing byte arrives; data is gated so idle outputs read zero.
    assign im_we    = (state == I_LO) && rx_valid;
    assign im_addr  = im_we ? idx : '0;
    assign im_wdata = im_we ? rx_word : '0;
    assign dm_we    = (state == D_BYTE) && rx_valid;
    assign dm_wdata = dm_we ? rx_data : '0;

    always_comb begin
        dm_addr = '0;
        case (state)
            D_BYTE:          dm_addr = idx;
            RD_REQ, RD_WAIT: dm_addr = rd_idx;
            default:         dm_addr = '0;
        endcase
    end

    always_comb begin
        status = 2'b00;
        case (state)
            IC_HI, IC_LO, I_HI, I_LO: status = 2'b01;
            DC_HI, DC_LO, D_BYTE:     status = 2'b10;
            RUN:                      status = 2'b11;
            default:                  status = 2'b00;
        endcase
    end

    assign busy = !((state == IDLE) || (state == DONE) || (state == ERR));
    assign err  = (state == ERR);

endmodule
